// File: rtl/pulse_interval_capture.sv
// Measures clk cycles between rising edges of an async pulse; result visible 3 clks after the sampled rise.
// valid/ready output; an unaccepted result is overwritten by the next one and flagged via sticky overrun.
module pulse_interval_capture #(
  parameter int Width   = 16,
  parameter int Timeout = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pulse_in,
  output logic [Width-1:0] period,
  output logic             valid,
  input  logic             ready,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [Width-1:0] TimeoutVal = Width'(Timeout);
  localparam logic [Width-1:0] One        = Width'(1);

  state_t           state, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             edge_det;
  logic             new_res;
  logic [Width-1:0] res_val;

  // s1/s2 form the synchronizer; s3 only exists to detect the rising edge of s2
  assign edge_det = s2_q & ~s3_q;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    new_res   = 1'b0;
    res_val   = '0;
    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (edge_det) begin
            cnt_d     = One;
            timeout_d = 1'b0;
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            new_res   = 1'b1;
            res_val   = cnt_q;
            cnt_d     = One;
            timeout_d = 1'b0;
          end else if (cnt_q == TimeoutVal) begin
            // period 0 signals a stalled source
            new_res   = 1'b1;
            res_val   = '0;
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + One;
          end
        end
        default: state_d = IDLE;
      endcase
      if (new_res) begin
        period_d = res_val;
        valid_d  = 1'b1;
        if (valid_q && !ready) overrun_d = 1'b1;
      end else if (valid_q && ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_d;
      s1_q      <= pulse_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_interval_capture.sv
// Directed bench: each table row holds inputs for n clocks, then checks all four outputs.
module tb_pulse_interval_capture;

  logic        clk;
  logic        reset;
  logic        en;
  logic        pulse_in;
  logic [15:0] period;
  logic        valid;
  logic        ready;
  logic        timeout;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          pin;
    int          n;
    bit          ev;
    logic [15:0] ep;
    bit          et;
    bit          eo;
  } vec_t;

  vec_t tbl[$];

  pulse_interval_capture #(.Width(16), .Timeout(500)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pulse_in (pulse_in),
    .period   (period),
    .valid    (valid),
    .ready    (ready),
    .timeout  (timeout),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input bit ev, input logic [15:0] ep, input bit et, input bit eo);
    chk("valid", idx, 32'(valid), 32'(ev));
    chk("period", idx, 32'(period), 32'(ep));
    chk("timeout", idx, 32'(timeout), 32'(et));
    chk("overrun", idx, 32'(overrun), 32'(eo));
  endtask

  function automatic vec_t mk(bit rst, bit e, bit rdy, bit pin, int n,
                              bit ev, logic [15:0] ep, bit et, bit eo);
    vec_t v;
    v.rst = rst; v.en = e; v.rdy = rdy; v.pin = pin; v.n = n;
    v.ev = ev; v.ep = ep; v.et = et; v.eo = eo;
    return v;
  endfunction

  initial begin
    // rst en rdy pin n | valid period timeout overrun
    tbl.push_back(mk(1,0,1,0,2,   0,0,0,0));
    tbl.push_back(mk(1,1,1,0,5,   0,0,0,0));
    tbl.push_back(mk(1,1,1,1,3,   0,0,0,0));   // first edge only arms
    tbl.push_back(mk(1,1,1,1,7,   0,0,0,0));
    tbl.push_back(mk(1,1,1,0,90,  0,0,0,0));
    tbl.push_back(mk(1,1,1,1,2,   0,0,0,0));
    tbl.push_back(mk(1,1,1,1,1,   1,100,0,0)); // 3 clks after the rise
    tbl.push_back(mk(1,1,1,1,1,   0,100,0,0));
    tbl.push_back(mk(1,1,1,1,6,   0,100,0,0));
    tbl.push_back(mk(1,1,1,0,90,  0,100,0,0));
    tbl.push_back(mk(1,1,0,1,3,   1,100,0,0));
    tbl.push_back(mk(1,1,0,1,7,   1,100,0,0));
    tbl.push_back(mk(1,1,0,0,110, 1,100,0,0));
    tbl.push_back(mk(1,1,0,1,3,   1,120,0,1)); // overwrite without accept
    tbl.push_back(mk(1,1,1,1,1,   0,120,0,1));
    tbl.push_back(mk(1,1,1,1,6,   0,120,0,1));
    tbl.push_back(mk(1,1,1,0,42,  0,120,0,1)); // counter now 50
    tbl.push_back(mk(1,0,1,0,1,   0,120,0,0));
    tbl.push_back(mk(1,1,1,0,3,   0,120,0,0));
    tbl.push_back(mk(1,1,1,1,3,   0,120,0,0));
    tbl.push_back(mk(1,1,1,1,7,   0,120,0,0));
    tbl.push_back(mk(1,1,1,0,70,  0,120,0,0));
    tbl.push_back(mk(1,1,1,1,3,   1,80,0,0));
    tbl.push_back(mk(1,1,1,1,1,   0,80,0,0));
    tbl.push_back(mk(1,1,0,1,6,   0,80,0,0));
    tbl.push_back(mk(1,1,0,0,40,  0,80,0,0));
    tbl.push_back(mk(1,1,0,1,3,   1,50,0,0));
    tbl.push_back(mk(1,1,0,1,7,   1,50,0,0));
    tbl.push_back(mk(1,1,0,0,20,  1,50,0,0));
    tbl.push_back(mk(1,1,0,1,2,   1,50,0,0));
    tbl.push_back(mk(1,1,1,1,1,   1,30,0,0));  // new result with accept same cycle
    tbl.push_back(mk(1,1,1,1,1,   0,30,0,0));
    tbl.push_back(mk(1,1,1,1,5,   0,30,0,0));
    tbl.push_back(mk(1,1,1,0,493, 0,30,0,0));  // counter at Timeout, not yet published
    tbl.push_back(mk(1,1,1,0,1,   1,0,1,0));
    tbl.push_back(mk(1,1,1,0,1,   0,0,1,0));
    tbl.push_back(mk(1,1,1,0,20,  0,0,1,0));
    tbl.push_back(mk(1,1,1,1,2,   0,0,1,0));
    tbl.push_back(mk(1,1,1,1,1,   0,0,0,0));   // edge clears timeout, no result
    tbl.push_back(mk(1,1,1,1,7,   0,0,0,0));
    tbl.push_back(mk(1,1,1,0,63,  0,0,0,0));
    tbl.push_back(mk(1,1,0,1,3,   1,73,0,0));
    tbl.push_back(mk(0,1,0,1,1,   0,0,0,0));   // reset mid-measurement
    tbl.push_back(mk(1,1,1,1,5,   0,0,0,0));
    tbl.push_back(mk(1,1,1,0,60,  0,0,0,0));
    tbl.push_back(mk(1,1,1,1,3,   1,65,0,0));

    reset    = 1'b0;
    en       = 1'b0;
    ready    = 1'b0;
    pulse_in = 1'b0;

    // reset held while the pulse line toggles every clock
    for (int i = 0; i < 3; i++) begin
      pulse_in = ~pulse_in;
      tick();
      chk_all(-1 - i, 1'b0, 16'd0, 1'b0, 1'b0);
    end

    for (int r = 0; r < tbl.size(); r++) begin
      reset    = tbl[r].rst;
      en       = tbl[r].en;
      ready    = tbl[r].rdy;
      pulse_in = tbl[r].pin;
      repeat (tbl[r].n) tick();
      chk_all(r, tbl[r].ev, tbl[r].ep, tbl[r].et, tbl[r].eo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
